// File: rtl/msg_stream_pkg.sv
// Shared types and message ROM contents for msg_char_streamer.
// The ROM image holds every message back to back; MSG_BASE/MSG_LEN locate each one.
package msg_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int          PKG_NUM_MSG = 4;
  localparam int          LEN_W       = 8;
  localparam int unsigned ROM_DEPTH   = 23;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // msg0 "Soy de Zacapa", msg1 "Guatemala", msg2 "", msg3 "A"
  localparam logic [LEN_W-1:0] MSG_LEN  [PKG_NUM_MSG] = '{8'd13, 8'd9, 8'd0, 8'd1};
  localparam int unsigned      MSG_BASE [PKG_NUM_MSG] = '{0, 13, 22, 22};

  // Leftmost character of the literal is address 0.
  localparam logic [8*ROM_DEPTH-1:0] ROM_IMAGE = "Soy de ZacapaGuatemalaA";

  function automatic logic [7:0] rom_byte(input int unsigned addr);
    logic [8*ROM_DEPTH-1:0] img;
    img = ROM_IMAGE;
    if (addr < ROM_DEPTH) begin
      return img[8*(ROM_DEPTH-1-addr) +: 8];
    end
    return 8'h00;
  endfunction

endpackage

// File: rtl/msg_char_streamer_if.sv
// Character stream toward a UART or display driver.
// Handshake: a byte transfers on a clk edge where char_valid and out_rdy are both 1;
// while char_valid=1 and out_rdy=0 the master holds char_out and char_idx stable.
interface msg_char_streamer_if #(
  parameter int IDX_W = 7
) ();

  logic [7:0]       char_out;
  logic             char_valid;
  logic [IDX_W-1:0] char_idx;
  logic             out_rdy;

  modport master (
    output char_out,
    output char_valid,
    output char_idx,
    input  out_rdy
  );

  modport slave (
    input  char_out,
    input  char_valid,
    input  char_idx,
    output out_rdy
  );

endinterface

// File: rtl/msg_rom.sv
// Synchronous-read message ROM, one cycle of latency, output held between reads.
// With MSG_STREAM_CRLF_EN defined, indices len and len+1 read back CR and LF.
module msg_rom
  import msg_stream_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             rd_en,
  input  logic [SEL_W-1:0] sel,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       data_o
);

  logic [7:0]       data_d;
  logic [7:0]       data_q;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] idx_ext;

  always_comb begin
    len     = MSG_LEN[sel];
    idx_ext = LEN_W'(idx);
    data_d  = 8'h00;
    if (idx_ext < len) begin
      data_d = rom_byte(MSG_BASE[sel] + 32'(idx));
    end
`ifdef MSG_STREAM_CRLF_EN
    else if (idx_ext == len) begin
      data_d = CHAR_CR;
    end else begin
      data_d = CHAR_LF;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= 8'h00;
    end else if (ena && rd_en) begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/msg_char_streamer.sv
// Streams a stored ASCII message byte by byte over a valid/ready channel.
// Optional MSG_STREAM_CRLF_EN appends CR, LF after every message.
module msg_char_streamer
  import msg_stream_pkg::*;
#(
  parameter int NUM_MSG = 4,
  parameter int SEL_W   = 2,
  parameter int MAX_LEN = 128,
  parameter int IDX_W   = 7,
  parameter int RATE_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [SEL_W-1:0]    msg_sel,
  input  logic                start,
  input  logic                loop_mode,
  input  logic [RATE_W-1:0]   rate_div,
  output logic                busy,
  output logic                done,
  output state_t              dbg_state_o,
  msg_char_streamer_if.master stream
);

  if (IDX_W != $clog2(MAX_LEN) || SEL_W != ((NUM_MSG > 1) ? $clog2(NUM_MSG) : 1)) begin : g_param_check
    $error("msg_char_streamer: IDX_W/SEL_W inconsistent with MAX_LEN/NUM_MSG");
  end

`ifdef MSG_STREAM_CRLF_EN
  localparam logic [LEN_W-1:0] TAIL_LEN = LEN_W'(2);
`else
  localparam logic [LEN_W-1:0] TAIL_LEN = LEN_W'(0);
`endif

  state_t            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic              loop_q;
  logic [IDX_W-1:0]  idx_q;
  logic [RATE_W-1:0] gap_cnt_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  logic [SEL_W-1:0]  sel_eff;
  logic [LEN_W-1:0]  cur_len;
  logic              last_byte;
  logic [7:0]        rom_data;

  // Out-of-range selects fall back to message 0.
  assign sel_eff   = (int'(msg_sel) < NUM_MSG) ? msg_sel : '0;
  assign cur_len   = MSG_LEN[sel_q] + TAIL_LEN;
  assign last_byte = (LEN_W'(idx_q) == (cur_len - LEN_W'(1)));

  msg_rom #(
    .SEL_W (SEL_W),
    .IDX_W (IDX_W)
  ) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .rd_en  (state_q == ST_FETCH),
    .sel    (sel_q),
    .idx    (idx_q),
    .data_o (rom_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      loop_q    <= 1'b0;
      idx_q     <= '0;
      gap_cnt_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (ena) begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sel_q   <= sel_eff;
            loop_q  <= loop_mode;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          // Only an empty message can reach FETCH with nothing to send.
          if (cur_len == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            valid_q <= 1'b1;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (stream.out_rdy) begin
            valid_q <= 1'b0;
            if (last_byte && !loop_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q <= last_byte ? '0 : idx_q + IDX_W'(1);
              if (rate_div != '0) begin
                gap_cnt_q <= rate_div;
                state_q   <= ST_GAP;
              end else begin
                state_q <= ST_FETCH;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q <= RATE_W'(1)) begin
            state_q <= ST_FETCH;
          end else begin
            gap_cnt_q <= gap_cnt_q - RATE_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stream.char_out   = rom_data;
  assign stream.char_valid = valid_q;
  assign stream.char_idx   = idx_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_msg_char_streamer.sv
// Directed self-checking bench for msg_char_streamer (default messages).
// Expected byte streams are built from the message strings, plus CR/LF when MSG_STREAM_CRLF_EN is set.
module tb_msg_char_streamer;
  import msg_stream_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [1:0]  msg_sel;
  logic        start;
  logic        loop_mode;
  logic [15:0] rate_div;
  logic        busy;
  logic        done;
  state_t      dbg_state;

  msg_char_streamer_if #(.IDX_W(7)) sif ();

  msg_char_streamer #(
    .NUM_MSG (4),
    .SEL_W   (2),
    .MAX_LEN (128),
    .IDX_W   (7),
    .RATE_W  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .msg_sel     (msg_sel),
    .start       (start),
    .loop_mode   (loop_mode),
    .rate_div    (rate_div),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state),
    .stream      (sif)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input int sel);
    string s;
    exp_q.delete();
    case (sel)
      0:       s = "Soy de Zacapa";
      1:       s = "Guatemala";
      2:       s = "";
      default: s = "A";
    endcase
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`ifdef MSG_STREAM_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  // Drives a start pulse; returns in the FETCH cycle after acceptance.
  task automatic start_msg(input logic [1:0] sel, input logic lp, input logic [15:0] rate);
    msg_sel   = sel;
    loop_mode = lp;
    rate_div  = rate;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_fetch_novalid", 32'(sif.char_valid), 32'd0);
  endtask

  // Called in the SEND cycle of byte 'first' with out_rdy=1, rate_div=0, one-shot.
  task automatic drain(input int first);
    int n;
    n = exp_q.size();
    for (int i = first; i < n; i++) begin
      chk($sformatf("byte%0d_valid", i), 32'(sif.char_valid), 32'd1);
      chk($sformatf("byte%0d_char", i), 32'(sif.char_out), 32'(exp_q[i]));
      chk($sformatf("byte%0d_idx", i), 32'(sif.char_idx), 32'(i));
      chk($sformatf("byte%0d_nodone", i), 32'(done), 32'd0);
      if (i == 3) start = 1'b1;
      msg_sel = 2'($urandom_range(0, 3));
      tick();
      start = 1'b0;
      if (i != n - 1) begin
        chk($sformatf("byte%0d_gap_novalid", i), 32'(sif.char_valid), 32'd0);
        tick();
      end
    end
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_novalid", 32'(sif.char_valid), 32'd0);
    tick();
    chk("end_done_pulse", 32'(done), 32'd0);
    chk("end_idle", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_exp;
    int n;
    rst_n       = 1'b0;
    ena         = 1'b1;
    msg_sel     = 2'd0;
    start       = 1'b0;
    loop_mode   = 1'b0;
    rate_div    = 16'd0;
    sif.out_rdy = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_char", 32'(sif.char_out), 32'h00);
    chk("rst_valid", 32'(sif.char_valid), 32'd0);
    chk("rst_idx", 32'(sif.char_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // msg0 back-to-back
    load_exp(0);
    start_msg(2'd0, 1'b0, 16'd0);
    tick();
    chk("msg0_first", 32'(sif.char_out), 32'h53);
    drain(0);

    // msg1 with 5-cycle stall on byte 0
    load_exp(1);
    sif.out_rdy = 1'b0;
    start_msg(2'd1, 1'b0, 16'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(sif.char_valid), 32'd1);
      chk("stall_char", 32'(sif.char_out), 32'h47);
      chk("stall_idx", 32'(sif.char_idx), 32'd0);
      tick();
    end
    sif.out_rdy = 1'b1;
    chk("stall_release_char", 32'(sif.char_out), 32'h47);
    tick();
    chk("stall_accepted", 32'(sif.char_valid), 32'd0);
    chk("stall_next_idx", 32'(sif.char_idx), 32'd1);
    tick();
    drain(1);

    // msg3 loop, rate 3, rate changed to 1 mid-gap
    load_exp(3);
    n = exp_q.size();
    start_msg(2'd3, 1'b1, 16'd3);
    tick();
    for (int k = 0; k < 3 * n; k++) begin
      chk("loop_valid", 32'(sif.char_valid), 32'd1);
      chk("loop_char", 32'(sif.char_out), 32'(exp_q[k % n]));
      chk("loop_nodone", 32'(done), 32'd0);
      tick();
      idle_exp = (k <= 1) ? 4 : 2;
      for (int j = 0; j < idle_exp; j++) begin
        if (k == 1 && j == 0) rate_div = 16'd1;
        chk("loop_idle_novalid", 32'(sif.char_valid), 32'd0);
        chk("loop_idle_nodone", 32'(done), 32'd0);
        chk("loop_idle_busy", 32'(busy), 32'd1);
        tick();
      end
    end
    chk("loop_resume_valid", 32'(sif.char_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    loop_mode = 1'b0;
    rate_div  = 16'd0;
    chk("loop_rst_busy", 32'(busy), 32'd0);
    chk("loop_rst_valid", 32'(sif.char_valid), 32'd0);

    // msg2 empty
    load_exp(2);
    start_msg(2'd2, 1'b0, 16'd0);
    if (exp_q.size() == 0) begin
      tick();
      chk("empty_done", 32'(done), 32'd1);
      chk("empty_novalid", 32'(sif.char_valid), 32'd0);
      chk("empty_busy", 32'(busy), 32'd0);
      tick();
      chk("empty_done_pulse", 32'(done), 32'd0);
      chk("empty_idle", 32'(dbg_state), 32'(ST_IDLE));
    end else begin
      tick();
      drain(0);
    end

    // reset during byte 5 of msg0, then replay with an ena freeze
    load_exp(0);
    start_msg(2'd0, 1'b0, 16'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      tick();
    end
    chk("b5_char", 32'(sif.char_out), 32'h65);
    chk("b5_idx", 32'(sif.char_idx), 32'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_valid", 32'(sif.char_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_char", 32'(sif.char_out), 32'h00);
    chk("abort_idx", 32'(sif.char_idx), 32'd0);
    start_msg(2'd0, 1'b0, 16'd0);
    tick();
    chk("replay_char", 32'(sif.char_out), 32'h53);
    chk("replay_valid", 32'(sif.char_valid), 32'd1);
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("freeze_valid", 32'(sif.char_valid), 32'd1);
      chk("freeze_char", 32'(sif.char_out), 32'h53);
      chk("freeze_idx", 32'(sif.char_idx), 32'd0);
      chk("freeze_state", 32'(dbg_state), 32'(ST_SEND));
    end
    ena = 1'b1;
    tick();
    chk("unfreeze_accept", 32'(sif.char_valid), 32'd0);
    chk("unfreeze_idx", 32'(sif.char_idx), 32'd1);
    tick();
    drain(1);

    // start held through DONE restarts msg3
    load_exp(3);
    n = exp_q.size();
    start_msg(2'd3, 1'b0, 16'd0);
    tick();
    for (int i = 0; i < n - 1; i++) begin
      chk("rs_char", 32'(sif.char_out), 32'(exp_q[i]));
      tick();
      tick();
    end
    chk("rs_last_char", 32'(sif.char_out), 32'(exp_q[n-1]));
    msg_sel = 2'd3;
    start   = 1'b1;
    tick();
    chk("rs_done", 32'(done), 32'd1);
    chk("rs_done_busy", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    chk("rs_restart_state", 32'(dbg_state), 32'(ST_FETCH));
    chk("rs_restart_busy", 32'(busy), 32'd1);
    chk("rs_restart_nodone", 32'(done), 32'd0);
    tick();
    drain(0);

    // ena low blocks start in IDLE
    ena   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ena   = 1'b1;
    chk("ena_blocks_start_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("ena_blocks_start_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
